mm_host_sequencer: RTL

- Host-side sequencer for the Montgomery multiplier core; drives the BRAM port shared with the core, and the core's start/reset.
- Accepts operand words on a valid/ready input stream and writes them to the operand BRAM region.
- Pulses start to the core, waits for its done, reads the result words back and emits them on a valid/ready output stream.
- Resets the core afterwards so it is ready for the next operation.

---
 rtl/mm_host_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mm_host_sequencer.sv
// rtl/mm_host_sequencer.sv - Montgomery core host sequencer: load operands, start, read result, reset core
// Define MM_SEQ_TIMEOUT_EN to abort a core that never raises done within TIMEOUT_CYCLES.
module mm_host_sequencer #(
  parameter int s              = 16,
  parameter int RES_BASE       = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [16:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [16:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        bram_en_o,
  output logic        bram_we_o,
  output logic [31:0] bram_addr_o,
  output logic [31:0] bram_din_o,
  input  logic [31:0] bram_dout_i,
  output logic        core_start_o,
  output logic        core_reset_o,
  input  logic        core_done_i,
  output logic        busy_o,
  output logic        error_o
);

  localparam int CW = $clog2(4 * s);
  localparam logic [CW-1:0] LAST_RES  = CW'(s - 1);
  localparam logic [CW-1:0] LOAD_DONE = CW'(3 * s + 1);
  localparam logic [CW-1:0] RB        = CW'(RES_BASE);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, READ, CAPT, HOLD, CLR} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          en_d, we_d, en_q, we_q;
  logic [CW-1:0] addr_d, addr_q;
  logic [16:0]   din_d, din_q;
  logic [16:0]   data_q;
  logic          valid_q;
  logic          core_rst_q;
  logic          in_hs, out_hs, timeout;
  logic          unused_dout;

  // Ready is held off while the core reset pulse is still out, and once all 3s+1 limbs are in.
  assign s_ready_o    = ((state == IDLE) && !core_rst_q) || ((state == LOAD) && (cnt != LOAD_DONE));
  assign in_hs        = s_valid_i && s_ready_o;
  assign out_hs       = valid_q && m_ready_i;
  assign m_data_o     = data_q;
  assign m_valid_o    = valid_q;
  assign bram_en_o    = en_q;
  assign bram_we_o    = we_q;
  assign bram_addr_o  = {{(32 - CW){1'b0}}, addr_q};
  assign bram_din_o   = {15'd0, din_q};
  assign core_start_o = (state == START);
  assign core_reset_o = core_rst_q;
  assign busy_o       = (state != IDLE);
  assign unused_dout  = ^bram_dout_i[31:17];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state)
      IDLE: if (in_hs) begin
        en_d = 1'b1; we_d = 1'b1; addr_d = '0; din_d = s_data_i;
        cnt_d = CW'(1); state_d = LOAD;
      end
      // The extra LOAD cycle lets the final write reach the BRAM before the core is started.
      LOAD: if (cnt == LOAD_DONE) begin
        state_d = START;
      end else if (in_hs) begin
        en_d = 1'b1; we_d = 1'b1; addr_d = cnt; din_d = s_data_i;
        cnt_d = cnt + CW'(1);
      end
      START: state_d = WAIT;
      WAIT: if (core_done_i) begin
        cnt_d = '0; en_d = 1'b1; addr_d = RB; state_d = READ;
      end else if (timeout) begin
        state_d = CLR;
      end
      READ: state_d = CAPT;
      CAPT: state_d = HOLD;
      HOLD: if (out_hs) begin
        cnt_d = cnt + CW'(1);
        if (cnt == LAST_RES) begin
          state_d = CLR;
        end else begin
          en_d = 1'b1; addr_d = RB + cnt + CW'(1); state_d = READ;
        end
      end
      CLR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt        <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      cnt        <= cnt_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      core_rst_q <= (state_d == CLR);
      if (state == CAPT) begin
        data_q  <= bram_dout_i[16:0];
        valid_q <= 1'b1;
      end else if (out_hs) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef MM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign timeout = (state == WAIT) && !core_done_i && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign error_o = err_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT) ? tmo_cnt + TW'(1) : '0;
      if (timeout)                     err_q <= 1'b1;
      else if ((state == IDLE) && in_hs) err_q <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

endmodule
